// File: rtl/jtag_tap_controller_if.sv
// TAP pin bundle between a JTAG host and the TAP controller.
// Clock (TCK) and reset (TRST_n) are plain ports on the controller.
interface jtag_tap_controller_if #(
  parameter int unsigned IR_LENGTH = 4
);
  logic                 TMS;
  logic                 TDI;
  logic                 tdr_tdo;
  logic                 TDO;
  logic                 tdr_select;
  logic                 Capture_DR;
  logic                 Shift_DR;
  logic                 Update_DR;
  logic [IR_LENGTH-1:0] IR_OUT;
  logic [3:0]           tap_state;

  // Host side: drives the serial pins, observes everything else.
  modport master (
    output TMS, TDI, tdr_tdo,
    input  TDO, tdr_select, Capture_DR, Shift_DR, Update_DR, IR_OUT, tap_state
  );

  // TAP side.
  modport slave (
    input  TMS, TDI, tdr_tdo,
    output TDO, tdr_select, Capture_DR, Shift_DR, Update_DR, IR_OUT, tap_state
  );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register,
// built-in BYPASS / IDCODE registers and the final TDO mux.
// Optional macro TAP_IDCODE_EN: when defined the IDCODE register exists and
// reset/TLR load OPC_IDCODE; otherwise reset/TLR load BYPASS (all ones) and
// OPC_IDCODE behaves like any other BYPASS opcode.
module jtag_tap_controller #(
  parameter int unsigned          IR_LENGTH    = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1234_5677,
  parameter logic [IR_LENGTH-1:0] OPC_IDCODE   = IR_LENGTH'(4'b0001),
  parameter logic [IR_LENGTH-1:0] OPC_USER     = IR_LENGTH'(4'b0010)
) (
  input  logic                  TCK,
  input  logic                  TRST_n,
  jtag_tap_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

`ifdef TAP_IDCODE_EN
  localparam logic [IR_LENGTH-1:0] IR_RESET = OPC_IDCODE;
`else
  localparam logic [IR_LENGTH-1:0] IR_RESET = '1;
`endif

  tap_state_t           state;
  tap_state_t           state_nxt;
  logic                 capture_dr;
  logic                 shift_dr;
  logic                 update_dr;
  logic [IR_LENGTH-1:0] ir;
  logic [IR_LENGTH-1:0] ir_shift;
  logic                 tdr_select;
  logic                 bypass;
  logic                 idcode_bit;
  logic                 is_user;
  logic                 is_idcode;
  logic                 is_bypass;
  logic                 tdo_c;

  // TAP state transition table, TMS sampled on rising TCK.
  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TLR;
    case (s)
      TLR:    n = tms ? TLR    : RTI;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SH_DR;
      SH_DR:  n = tms ? EX1_DR : SH_DR;
      EX1_DR: n = tms ? UPD_DR : PAU_DR;
      PAU_DR: n = tms ? EX2_DR : PAU_DR;
      EX2_DR: n = tms ? UPD_DR : SH_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SH_IR;
      SH_IR:  n = tms ? EX1_IR : SH_IR;
      EX1_IR: n = tms ? UPD_IR : PAU_IR;
      PAU_IR: n = tms ? EX2_IR : PAU_IR;
      EX2_IR: n = tms ? UPD_IR : SH_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  assign state_nxt = next_state(state, bus.TMS);

  // State register with strobes registered from the next state, so each
  // strobe is high exactly while the FSM sits in its state.
  always_ff @(posedge TCK) begin
    if (!TRST_n) begin
      state      <= TLR;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
    end else begin
      state      <= state_nxt;
      capture_dr <= (state_nxt == CAP_DR);
      shift_dr   <= (state_nxt == SH_DR);
      update_dr  <= (state_nxt == UPD_DR);
    end
  end

  // Instruction shift/update; IR only changes at UPD_IR or TLR, so an
  // aborted scan never exposes a partial opcode.
  always_ff @(posedge TCK) begin
    if (!TRST_n) begin
      ir_shift   <= '0;
      ir         <= IR_RESET;
      tdr_select <= (IR_RESET == OPC_USER);
    end else begin
      case (state)
        CAP_IR:  ir_shift <= IR_LENGTH'(2'b01);
        SH_IR:   ir_shift <= {ir_shift[IR_LENGTH-2:0], bus.TDI};
        default: ir_shift <= ir_shift;
      endcase
      if (state == TLR) begin
        ir         <= IR_RESET;
        tdr_select <= (IR_RESET == OPC_USER);
      end else if (state == UPD_IR) begin
        ir         <= ir_shift;
        tdr_select <= (ir_shift == OPC_USER);
      end
    end
  end

  assign is_user = (ir == OPC_USER);
`ifdef TAP_IDCODE_EN
  assign is_idcode = (ir == OPC_IDCODE);
`else
  assign is_idcode = 1'b0;
`endif
  assign is_bypass = !is_user && !is_idcode;

  // BYPASS bit: captures 0, shifts TDI, holds when not selected.
  always_ff @(posedge TCK) begin
    if (!TRST_n) begin
      bypass <= 1'b0;
    end else if (is_bypass) begin
      if (state == CAP_DR) begin
        bypass <= 1'b0;
      end else if (state == SH_DR) begin
        bypass <= bus.TDI;
      end
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_shift;

  // IDCODE register: captures the device ID, shifts left with TDI into bit 0.
  always_ff @(posedge TCK) begin
    if (!TRST_n) begin
      idcode_shift <= '0;
    end else if (is_idcode) begin
      if (state == CAP_DR) begin
        idcode_shift <= IDCODE_VALUE;
      end else if (state == SH_DR) begin
        idcode_shift <= {idcode_shift[30:0], bus.TDI};
      end
    end
  end

  assign idcode_bit = idcode_shift[31];
`else
  // Without the IDCODE register the ID parameters are intentionally unused.
  logic unused_idcode_cfg;
  assign unused_idcode_cfg = ^{IDCODE_VALUE, OPC_IDCODE};
  assign idcode_bit        = 1'b0;
`endif

  // Final TDO mux; zero outside the two shift states.
  always_comb begin
    tdo_c = 1'b0;
    if (state == SH_IR) begin
      tdo_c = ir_shift[IR_LENGTH-1];
    end else if (state == SH_DR) begin
      if (is_user) begin
        tdo_c = bus.tdr_tdo;
      end else if (is_idcode) begin
        tdo_c = idcode_bit;
      end else begin
        tdo_c = bypass;
      end
    end
  end

  assign bus.TDO        = tdo_c;
  assign bus.tdr_select = tdr_select;
  assign bus.Capture_DR = capture_dr;
  assign bus.Shift_DR   = shift_dr;
  assign bus.Update_DR  = update_dr;
  assign bus.IR_OUT     = ir;
  assign bus.tap_state  = state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller. Expectations come from a
// transition table plus queue models of the selected shift paths.
module tb_jtag_tap_controller;

  localparam int unsigned IR_LEN = 4;
  localparam logic [31:0] ID_VAL = 32'h1234_5677;
`ifdef TAP_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam logic [3:0] IR_RST = ID_EN ? 4'b0001 : 4'b1111;

  logic TCK    = 1'b0;
  logic TRST_n = 1'b1;

  jtag_tap_controller_if #(.IR_LENGTH(IR_LEN)) bus ();

  jtag_tap_controller #(
    .IR_LENGTH   (IR_LEN),
    .IDCODE_VALUE(ID_VAL),
    .OPC_IDCODE  (4'b0001),
    .OPC_USER    (4'b0010)
  ) dut (
    .TCK   (TCK),
    .TRST_n(TRST_n),
    .bus   (bus)
  );

  always #5 TCK = ~TCK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_state;
  logic [3:0] m_ir;
  bit         ir_q[$];
  bit         dr_q[$];
  bit         last_tdo;
  bit         sh_tdi[$];
  bit         sh_tdo[$];

  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  function automatic bit m_user(input logic [3:0] ir);
    return ir == 4'b0010;
  endfunction

  function automatic bit m_idcode(input logic [3:0] ir);
    return ID_EN && (ir == 4'b0001);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic post_edge_checks();
    check("tap_state",  32'(bus.tap_state),  32'(m_state));
    check("ir_out",     32'(bus.IR_OUT),     32'(m_ir));
    check("tdr_select", 32'(bus.tdr_select), 32'(m_user(m_ir)));
    check("capture_dr", 32'(bus.Capture_DR), 32'(m_state == 3));
    check("shift_dr",   32'(bus.Shift_DR),   32'(m_state == 4));
    check("update_dr",  32'(bus.Update_DR),  32'(m_state == 8));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ir    = IR_RST;
    ir_q    = {1'b0, 1'b0, 1'b0, 1'b0};
    dr_q.delete();
  endtask

  // One TCK cycle: drive pins, check TDO before the edge, advance the model.
  task automatic tick(input bit tms, input bit tdi, input bit rst);
    bit exp_tdo;
    bus.TMS     = tms;
    bus.TDI     = tdi;
    bus.tdr_tdo = 1'($urandom_range(0, 1));
    TRST_n      = !rst;
    #1;
    exp_tdo = 1'b0;
    if (m_state == 11) exp_tdo = ir_q[0];
    else if (m_state == 4) exp_tdo = m_user(m_ir) ? bus.tdr_tdo : dr_q[0];
    last_tdo = bus.TDO;
    check("tdo", 32'(bus.TDO), 32'(exp_tdo));
    @(posedge TCK);
    if (rst) begin
      model_reset();
    end else begin
      case (m_state)
        0: m_ir = IR_RST;
        3: begin
          dr_q.delete();
          if (m_idcode(m_ir)) begin
            for (int i = 31; i >= 0; i--) dr_q.push_back(ID_VAL[i]);
          end else if (!m_user(m_ir)) begin
            dr_q.push_back(1'b0);
          end
        end
        4: if (!m_user(m_ir)) begin
          void'(dr_q.pop_front());
          dr_q.push_back(tdi);
        end
        10: ir_q = {1'b0, 1'b0, 1'b0, 1'b1};
        11: begin
          void'(ir_q.pop_front());
          ir_q.push_back(tdi);
        end
        15: m_ir = {ir_q[0], ir_q[1], ir_q[2], ir_q[3]};
        default: ;
      endcase
      m_state = tms ? nxt1[m_state] : nxt0[m_state];
    end
    #1;
    TRST_n = 1'b1;
    post_edge_checks();
  endtask

  // Full IR scan from RTI, ending back in RTI.
  task automatic ir_scan(input logic [3:0] val);
    logic [3:0] cap;
    cap = '0;
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, val[3 - i], 0);
      cap = {cap[2:0], last_tdo};
    end
    check("ir_capture_stream", 32'(cap), 32'(4'b0001));
    tick(1, 0, 0); tick(0, 0, 0);
    check("ir_after_update", 32'(bus.IR_OUT), 32'(val));
    check("tdr_select_after_update", 32'(bus.tdr_select), 32'(val == 4'b0010));
  endtask

  // DR scan of n bits from RTI, optional pause after pause_at bits.
  task automatic dr_scan(input int n, input int pause_at);
    bit b;
    sh_tdi.delete();
    sh_tdo.delete();
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      tick((i == n - 1) || (i == pause_at - 1), b, 0);
      sh_tdi.push_back(b);
      sh_tdo.push_back(last_tdo);
      if (i == pause_at - 1) begin
        for (int p = 0; p < 4; p++) tick(0, 1'($urandom_range(0, 1)), 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
      end
    end
    tick(1, 0, 0); tick(0, 0, 0);
  endtask

  initial begin
    logic [31:0] stream;
    logic [31:0] exp_stream;
    bus.TMS     = 1'b1;
    bus.TDI     = 1'b0;
    bus.tdr_tdo = 1'b0;

    // Reset
    TRST_n = 1'b0;
    @(posedge TCK);
    #1;
    TRST_n = 1'b1;
    model_reset();
    post_edge_checks();
    check("reset_tdo", 32'(bus.TDO), 32'd0);

    // Random wander, then five TMS=1 must land in TLR
    for (int i = 0; i < 12; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    check("five_tms_to_tlr", 32'(bus.tap_state), 32'd0);
    check("tlr_ir_default", 32'(bus.IR_OUT), 32'(IR_RST));

    // Walk 0,1,0,0 into SH_DR, then read the default DR for 32 bits
    tick(0, 0, 0); check("walk_rti", 32'(bus.tap_state), 32'd1);
    tick(1, 0, 0); check("walk_sel_dr", 32'(bus.tap_state), 32'd2);
    tick(0, 0, 0); check("walk_cap_dr", 32'(bus.Capture_DR), 32'd1);
    tick(0, 0, 0); check("walk_sh_dr", 32'(bus.Shift_DR), 32'd1);
    sh_tdi.delete();
    stream = '0;
    for (int i = 0; i < 32; i++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      tick(i == 31, b, 0);
      sh_tdi.push_back(b);
      stream = {stream[30:0], last_tdo};
    end
    if (ID_EN) begin
      exp_stream = ID_VAL;
    end else begin
      exp_stream = '0;
      for (int i = 0; i < 32; i++) exp_stream = {exp_stream[30:0], (i == 0) ? 1'b0 : sh_tdi[i - 1]};
    end
    check("default_dr_stream", stream, exp_stream);
    tick(1, 0, 0); tick(0, 0, 0);

    // USER instruction, DR traffic goes to tdr_tdo
    ir_scan(4'b0010);
    dr_scan(10, 0);

    // BYPASS with a pause in the middle: TDO is TDI delayed one shift
    ir_scan(4'b1111);
    dr_scan(5, 3);
    for (int i = 0; i < 5; i++)
      check("pause_bypass_delay", 32'(sh_tdo[i]), 32'((i == 0) ? 1'b0 : sh_tdi[i - 1]));

    // Undefined opcode behaves as BYPASS
    ir_scan(4'b0101);
    dr_scan(8, 0);
    for (int i = 0; i < 8; i++)
      check("undef_bypass_delay", 32'(sh_tdo[i]), 32'((i == 0) ? 1'b0 : sh_tdi[i - 1]));

    // Explicit IDCODE opcode, read past the 32-bit boundary
    ir_scan(4'b0001);
    dr_scan(36, 0);
    stream = '0;
    for (int i = 0; i < 32; i++) stream = {stream[30:0], sh_tdo[i]};
    exp_stream = ID_EN ? ID_VAL : {1'b0, 31'(0)};
    if (!ID_EN)
      for (int i = 0; i < 32; i++) exp_stream = {exp_stream[30:0], (i == 0) ? 1'b0 : sh_tdi[i - 1]};
    check("idcode_opcode_stream", stream, exp_stream);

    // Reset mid IR scan aborts without exposing a partial IR
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    tick(0, 0, 0); tick(0, 0, 0);
    tick(0, 1, 1);
    check("abort_state_tlr", 32'(bus.tap_state), 32'd0);
    check("abort_ir_default", 32'(bus.IR_OUT), 32'(IR_RST));

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
